// File: rtl/ufm_page_arbiter.sv
// ufm_page_arbiter
//   Round-robin arbiter that shares a single UFM page reader between two
//   requesters. The winner's page address is latched at grant. The arbiter
//   pulses rd_start, forwards PAGE_BYTES bytes to the winner, and then pulses
//   done for that requester. A watchdog aborts the page (err with done) if the
//   reader goes quiet for TIMEOUT unstalled cycles.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req0/1, addr0/1       page-read request (level) and page address
//   stall0/1              requester back-pressure, forwarded as rd_stall
//   gnt0/1                registered grant, held from START through DONE
//   data, data_stb0/1     byte from the reader, strobed to the granted side
//   done0/1, err          end-of-page pulse; err marks an aborted page
//   rd_start, rd_addr     reader start pulse and page address
//   rd_stall              stall to the reader
//   rd_data, rd_data_stb  reader byte and byte valid
//   rd_ready              reader idle
module ufm_page_arbiter #(
  parameter int unsigned PAGE_BYTES = 16,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              stall0,
  input  logic              stall1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [7:0]        data,
  output logic              data_stb0,
  output logic              data_stb1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_stall,
  input  logic [7:0]        rd_data,
  input  logic              rd_data_stb,
  input  logic              rd_ready
);

  localparam int unsigned CNT_W = $clog2(PAGE_BYTES + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAGE_BYTES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic              abort, abort_nxt;
  logic              last_gnt1, last_gnt1_nxt;
  logic              gnt0_nxt, gnt1_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              pick1;
  logic              xfer_stb;

  // last_gnt1=1 means requester 1 was served last, so requester 0 wins a tie.
  assign pick1    = req1 & (~req0 | ~last_gnt1);
  assign xfer_stb = (state == XFER) & rd_data_stb;

  assign data      = rd_data;
  assign data_stb0 = xfer_stb & gnt0;
  assign data_stb1 = xfer_stb & gnt1;
  assign rd_start  = (state == START);
  assign done0     = (state == DONE) & gnt0;
  assign done1     = (state == DONE) & gnt1;
  assign err       = (state == DONE) & abort;
  assign rd_stall  = ((state == START) | (state == XFER)) &
                     ((gnt0 & stall0) | (gnt1 & stall1));

  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    wd_cnt_nxt    = wd_cnt;
    abort_nxt     = abort;
    last_gnt1_nxt = last_gnt1;
    gnt0_nxt      = gnt0;
    gnt1_nxt      = gnt1;
    rd_addr_nxt   = rd_addr;
    case (state)
      IDLE: begin
        if (rd_ready && (req0 || req1)) begin
          gnt0_nxt    = ~pick1;
          gnt1_nxt    = pick1;
          rd_addr_nxt = pick1 ? addr1 : addr0;
          state_nxt   = START;
        end
      end
      START: begin
        byte_cnt_nxt = '0;
        wd_cnt_nxt   = '0;
        state_nxt    = XFER;
      end
      XFER: begin
        if (rd_data_stb) begin
          byte_cnt_nxt = byte_cnt + 1'b1;
          wd_cnt_nxt   = '0;
          if (byte_cnt == LAST_BYTE) state_nxt = DONE;
        end else if (!rd_stall) begin
          // The increment that would bring the watchdog to TIMEOUT ends the page.
          wd_cnt_nxt = wd_cnt + 1'b1;
          if (wd_cnt == WD_LAST) begin
            abort_nxt = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        last_gnt1_nxt = gnt1;
        gnt0_nxt      = 1'b0;
        gnt1_nxt      = 1'b0;
        abort_nxt     = 1'b0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      wd_cnt    <= '0;
      abort     <= 1'b0;
      last_gnt1 <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rd_addr   <= '0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      wd_cnt    <= wd_cnt_nxt;
      abort     <= abort_nxt;
      last_gnt1 <= last_gnt1_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      rd_addr   <= rd_addr_nxt;
    end
  end

endmodule

// File: doc/ufm_page_arbiter.md
UFM_PAGE_ARBITER -- requirements
Module: ufm_page_arbiter

Interface
REQ-001 SHALL have parameter PAGE_BYTES, default 16, meaning bytes per UFM page transfer (2..255).
REQ-002 SHALL have parameter ADDR_W, default 11, meaning width of the UFM page address.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning idle cycles in XFER before abort (1..65535).
REQ-004 clk  in  1  sole clock, all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req0, req1  in  1 each  page-read request from requester 0 and 1; level held until done.
REQ-007 addr0, addr1  in  ADDR_W each  requested page address; sampled at grant.
REQ-008 stall0, stall1  in  1 each  requester back-pressure.
REQ-009 gnt0, gnt1  out  1 each  grant; one-hot or zero.
REQ-010 data  out  8  byte forwarded from the reader.
REQ-011 data_stb0, data_stb1  out  1 each  byte valid for the granted requester.
REQ-012 done0, done1  out  1 each  one-cycle end-of-transfer pulse.
REQ-013 err  out  1  one-cycle pulse coincident with done when the transfer aborted.
REQ-014 rd_start  out  1  one-cycle start pulse to the UFM reader.
REQ-015 rd_addr  out  ADDR_W  page address to the reader; stable from start to done.
REQ-016 rd_stall  out  1  stall to the reader.
REQ-017 rd_data  in  8; rd_data_stb  in  1; rd_ready  in  1  reader byte, byte valid, reader idle.

Function
REQ-018 SHALL implement FSM states IDLE, START, XFER, DONE.
REQ-019 IDLE: when rd_ready=1 and req0|req1, SHALL register the grant, latch the winner's addr into rd_addr, and go to START; otherwise stay.
REQ-020 Arbitration SHALL be round-robin: a single requester wins; when both request, the requester not granted last wins; after reset, requester 0 has priority.
REQ-021 START: rd_start=1 for exactly one cycle, then XFER; latency from req sampled in IDLE to rd_start is 1 cycle.
REQ-022 XFER: data SHALL equal rd_data combinationally and data_stbN = rd_data_stb & gntN; the non-granted stb stays 0.
REQ-023 rd_stall SHALL equal the granted requester's stall in START/XFER, and 0 otherwise.
REQ-024 A byte counter (width ceil(log2(PAGE_BYTES+1))) SHALL clear at START and increment on each rd_data_stb in XFER; the stb taking the count to PAGE_BYTES SHALL move the FSM to DONE on the next edge.
REQ-025 A watchdog counter SHALL clear on every rd_data_stb and at START, hold while rd_stall=1, and increment otherwise in XFER; reaching TIMEOUT SHALL move to DONE with the abort flag set.
REQ-026 DONE: doneN=1 for one cycle for the granted requester, err=abort flag; grant, abort flag cleared, last-grant pointer updated, then IDLE.
REQ-027 rd_data_stb outside XFER SHALL be ignored (no stb, no count).
REQ-028 Requester dropping req mid-transfer SHALL NOT abort; the page completes and done is still issued.
REQ-029 Re-arbitration SHALL be possible on the cycle after DONE (back-to-back transfers, minimum 1 IDLE cycle).
REQ-030 A requester still asserting req in IDLE after its done SHALL be granted again only if the other is not requesting.

Reset
REQ-031 On rst=1, immediately and asynchronously: FSM=IDLE, gnt0/1=0, rd_start=0, done0/1=0, err=0, counters=0, rd_addr=0, last-grant pointer=1 (requester 0 favoured).
REQ-032 rst mid-transfer SHALL abandon the transfer with no done or err pulse; combinational outputs SHALL follow from the reset state.

Verification
REQ-033 Single request: req0=1, addr0=0x005, rd_ready=1 -> gnt0 next edge, rd_start pulse with rd_addr=0x005, 16 data_stb0, done0 once, err=0.
REQ-034 Contention: req0=req1=1 after reset -> requester 0 served first, then requester 1, then requester 0 again if both are still requesting.
REQ-035 Stall: stall1=1 during requester 1's transfer for 2000 cycles -> rd_stall=1, no err; released -> transfer completes with done1.
REQ-036 Timeout: reader stops after 7 bytes, no stall -> after 1024 idle cycles done0=1 and err=1 the same cycle, then IDLE.
REQ-037 Async reset mid-XFER at byte 9 -> outputs clear without a clock edge, no done; the next request starts a clean 16-byte page.
REQ-038 Stray rd_data_stb in IDLE and a req drop mid-page -> no data_stb; the page still completes with done.
